// File: rtl/b_minus_2a_pkg.sv
// Shared definitions for the b_minus_2a_seq block: FSM state encoding and
// the default operand width.
package b_minus_2a_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // IDLE: waiting for a request; DBL: t = a + a; SUB: b + ~t + 1; RESP: result offered
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    SUB  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/b_minus_2a_seq_adder.sv
// seq_adder: plain WIDTH-bit adder with carry in and carry out. The only
// arithmetic resource of b_minus_2a_seq; it is reused for both steps.
module seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Extend by one bit so the carry-out falls out of the same addition
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/b_minus_2a.sv
// b_minus_2a_seq: two-requester, round-robin arbitrated unit computing
// (b - 2*a) mod 2^WIDTH on one shared adder over two cycles (DBL, SUB).
//
// Handshake rule (all three channels): a transfer happens on a rising clk
// edge where valid and ready are both high; a response, once valid, keeps
// rsp_id/rsp_o/rsp_cout stable until it is taken.
//
// Optional feature: define B_MINUS_2A_OVF_FLAG_EN to add rsp_ovf, the
// carry-out of the doubling step (2a did not fit in WIDTH bits).
//
// dbg_state exposes the FSM state for checkers.
module b_minus_2a_seq
  import b_minus_2a_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_cout,
  output logic             busy,
`ifdef B_MINUS_2A_OVF_FLAG_EN
  output logic             rsp_ovf,
`endif
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  logic             r_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_rsp_o;
  logic             r_rsp_cout;
  logic             r_rsp_id;
`ifdef B_MINUS_2A_OVF_FLAG_EN
  logic             r_t_cout;
  logic             r_rsp_ovf;
`endif

  logic             w_idle;
  logic             w_any_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // Grant: sole valid requester wins; on contention the priority pointer decides
  assign w_idle      = (r_state == IDLE);
  assign w_any_valid = req0_valid | req1_valid;
  assign w_gnt_id    = (req0_valid & req1_valid) ? r_ptr : req1_valid;
  assign w_accept    = w_idle & ~rst & w_any_valid;
  assign req0_ready  = w_accept & ~w_gnt_id;
  assign req1_ready  = w_accept &  w_gnt_id;

  assign rsp_valid = (r_state == RESP);
  assign busy      = ~w_idle;
  assign rsp_o     = r_rsp_o;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_id    = r_rsp_id;
  assign dbg_state = r_state;
`ifdef B_MINUS_2A_OVF_FLAG_EN
  assign rsp_ovf   = r_rsp_ovf;
`endif

  // Steer the shared adder: a + a in DBL, b + ~t + 1 in SUB, idle otherwise
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      DBL: begin
        w_add_a = r_a;
        w_add_b = r_a;
      end
      SUB: begin
        w_add_a   = r_b;
        w_add_b   = ~r_t;
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  seq_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Control FSM plus operand, intermediate and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_t        <= '0;
      r_rsp_o    <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_id   <= 1'b0;
`ifdef B_MINUS_2A_OVF_FLAG_EN
      r_t_cout   <= 1'b0;
      r_rsp_ovf  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_gnt_id ? req1_a : req0_a;
            r_b     <= w_gnt_id ? req1_b : req0_b;
            r_id    <= w_gnt_id;
            r_ptr   <= ~w_gnt_id;
            r_state <= DBL;
          end
        end
        DBL: begin
          r_t      <= w_sum;
`ifdef B_MINUS_2A_OVF_FLAG_EN
          r_t_cout <= w_cout;
`endif
          r_state  <= SUB;
        end
        SUB: begin
          r_rsp_o    <= w_sum;
          r_rsp_cout <= w_cout;
          r_rsp_id   <= r_id;
`ifdef B_MINUS_2A_OVF_FLAG_EN
          r_rsp_ovf  <= r_t_cout;
`endif
          r_state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b_minus_2a_seq.sv
// Directed bench for b_minus_2a_seq (WIDTH = 16). Expected results are
// hand-computed constants carried through an expected queue.
module tb_b_minus_2a_seq;
  import b_minus_2a_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready;
  logic         rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_o;
  logic [1:0]   dbg_state;
`ifdef B_MINUS_2A_OVF_FLAG_EN
  logic         rsp_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  // expected entry: {ovf, id, cout, o}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] cur_exp;

  b_minus_2a_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
`ifdef B_MINUS_2A_OVF_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: raise a request and queue its hand-computed result
  task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e_o, input logic e_cout, input logic e_ovf);
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    exp_q.push_back({e_ovf, id, e_cout, e_o});
  endtask

  // wait (bounded) for a grant, check who got it, take the accept edge,
  // then drop valid and scramble that requester's operands
  task automatic wait_accept(input logic exp_id);
    bit seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req0_ready | req1_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      chk("grant_timeout", 32'd0, 32'd1);
    end else begin
      chk("grant_ready", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      if (exp_id) begin
        req1_valid = 1'b0;
        req1_a = W'($urandom_range(0, 65535));
        req1_b = W'($urandom_range(0, 65535));
      end else begin
        req0_valid = 1'b0;
        req0_a = W'($urandom_range(0, 65535));
        req0_b = W'($urandom_range(0, 65535));
      end
    end
  endtask

  // response must appear on the third edge counted from the accept edge
  task automatic check_resp();
    @(negedge clk);
    chk("dbl_state", dbg_state, DBL);
    chk("dbl_busy", busy, 1);
    chk("dbl_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("sub_state", dbg_state, SUB);
    chk("sub_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("resp_rsp_valid", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
      cur_exp = '0;
    end else begin
      cur_exp = exp_q.pop_front();
    end
    chk("rsp_o", rsp_o, cur_exp[W-1:0]);
    chk("rsp_cout", rsp_cout, cur_exp[W]);
    chk("rsp_id", rsp_id, cur_exp[W+1]);
`ifdef B_MINUS_2A_OVF_FLAG_EN
    chk("rsp_ovf", rsp_ovf, cur_exp[W+2]);
`endif
  endtask

  // keep rsp_ready low: response and data must hold, nobody gets ready
  task automatic hold_resp(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_o", rsp_o, cur_exp[W-1:0]);
      chk("hold_id", rsp_id, cur_exp[W+1]);
      chk("hold_readies", {30'd0, req1_ready, req0_ready}, 0);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_state", dbg_state, IDLE);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;

    // reset state, readies gated while rst is high even with both valid
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_o", rsp_o, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_id", rsp_id, 0);
`ifdef B_MINUS_2A_OVF_FLAG_EN
    chk("rst_rsp_ovf", rsp_ovf, 0);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // req0 only: 85 - 42 = 43, no borrow
    drive_req(1'b0, 16'd21, 16'd85, 16'd43, 1'b1, 1'b0);
    wait_accept(1'b0);
    check_resp();
    handshake();

    // req1 only: 7 - 64 = 0xFFC7, borrow; held 5 cycles with req0 waiting
    drive_req(1'b1, 16'd32, 16'd7, 16'hFFC7, 1'b0, 1'b0);
    wait_accept(1'b1);
    check_resp();
    // 2a = 0x10002 -> t = 0x0002, ovf; 0 - 2 = 0xFFFE, borrow
    drive_req(1'b0, 16'h8001, 16'h0000, 16'hFFFE, 1'b0, 1'b1);
    hold_resp(5);
    handshake();
    wait_accept(1'b0);
    check_resp();
    handshake();

    // reset restores pointer to req0; both valid -> req0 then req1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b0, 16'd36, 16'd255, 16'd183, 1'b1, 1'b0);
    drive_req(1'b1, 16'd200, 16'd95, 16'hFECF, 1'b0, 1'b0);
    wait_accept(1'b0);
    check_resp();
    handshake();
    wait_accept(1'b1);
    check_resp();
    handshake();

    // rst during SUB discards the op (ptr would otherwise point at req1)
    req0_a = 16'd256; req0_b = 16'd5; req0_valid = 1'b1;
    wait_accept(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_sub", dbg_state, SUB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    // 10 - 6 = 4; 1 - 2 = 0xFFFF
    drive_req(1'b0, 16'd3, 16'd10, 16'd4, 1'b1, 1'b0);
    drive_req(1'b1, 16'd1, 16'd1, 16'hFFFF, 1'b0, 1'b0);
    wait_accept(1'b0);
    check_resp();
    handshake();
    wait_accept(1'b1);
    check_resp();
    handshake();

    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
